// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// No logic; used by the loader FSM and the byte assembler.
// No flow control here.
package program_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        CHECK,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, program-memory write port and status of the loader.
// Pure wiring, zero latency.
// Stream side uses byte_valid_i/byte_ready_o; the write port has no backpressure.
interface program_loader_if;

    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        prog_we_o;
    logic [31:0] prog_addr_o;
    logic [31:0] prog_data_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] word_count_o;

    modport master (
        output start_i, byte_i, byte_valid_i,
        input  byte_ready_o, prog_we_o, prog_addr_o, prog_data_o,
               cpu_reset_o, done_o, error_o, word_count_o
    );

    modport slave (
        input  start_i, byte_i, byte_valid_i,
        output byte_ready_o, prog_we_o, prog_addr_o, prog_data_o,
               cpu_reset_o, done_o, error_o, word_count_o
    );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Shifts bytes MSB-first into a 32-bit word and tracks the byte lane.
// Word updates on the edge that accepts the byte.
// No flow control; the caller gates shift_en with the handshake.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word,
    output logic        word_full
);

    logic [LANE_W-1:0] lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (shift_en) begin
            word <= {word[23:0], byte_dat};
            lane <= lane + 1'b1;
        end
    end

    // High while the next accepted byte completes the word.
    assign word_full = (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian image into program memory, then releases the core.
// Write strobe one cycle after the 4th byte of a word; 4 bytes per 5 cycles peak.
// byte_ready_o is decoded from state and drops during CHECK and WRITE.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 64
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(MEMORY_DEPTH);

    state_t            state, state_nxt;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  word_count;
    logic [LEN_W-1:0]  word_index;
    logic              byte_rdy;
    logic              accept;
    logic              last_word;
    logic              asm_clear;
    logic              asm_shift;
    logic [31:0]       asm_word;
    logic              asm_full;

    assign byte_rdy  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign accept    = bus.byte_valid_i && byte_rdy;
    assign last_word = (word_index == word_count - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_hi     <= '0;
            word_count <= '0;
            word_index <= '0;
        end else begin
            state <= state_nxt;
            if (state == LEN_HI && accept)
                len_hi <= bus.byte_i;
            if (state == LEN_LO && accept)
                word_count <= {len_hi, bus.byte_i};
            if (state == CHECK)
                word_index <= '0;
            else if (state == WRITE && !last_word)
                word_index <= word_index + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
        case (state)
            IDLE, DONE, ERROR: if (bus.start_i) state_nxt = LEN_HI;
            LEN_HI:            if (accept) state_nxt = LEN_LO;
            LEN_LO:            if (accept) state_nxt = CHECK;
            CHECK: begin
                if (word_count == '0) begin
                    state_nxt = DONE;
                end else if (word_count > MAX_WORDS) begin
                    state_nxt = ERROR;
                end else begin
                    asm_clear = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_full) state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = last_word ? DONE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_dat  (bus.byte_i),
        .word      (asm_word),
        .word_full (asm_full)
    );

    assign bus.byte_ready_o = byte_rdy;
    assign bus.prog_we_o    = (state == WRITE);
    assign bus.prog_addr_o  = {{(32 - LEN_W - 2){1'b0}}, word_index, 2'b00};
    assign bus.prog_data_o  = asm_word;
    assign bus.cpu_reset_o  = (state != DONE);
    assign bus.done_o       = (state == DONE);
    assign bus.error_o      = (state == ERROR);
    assign bus.word_count_o = word_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, zero, oversize, gaps, reset, reload.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader_if bus();

    program_loader #(.MEMORY_DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.prog_we_o === 1'b1) begin
            wr_addr.push_back(bus.prog_addr_o);
            wr_data.push_back(bus.prog_data_o);
            chk("ready_in_write", {31'd0, bus.byte_ready_o}, 32'd0);
        end
    end

    task automatic pulse_start();
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        n = 0;
        while (bus.byte_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'hxx;
    endtask

    task automatic send_stream(input logic [7:0] s[], input int max_gap);
        foreach (s[i]) send_byte(s[i], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.start_i = 1'b0;
        bus.byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.byte_ready_o}, 32'd0);
        chk({tag, "_we"},    {31'd0, bus.prog_we_o},    32'd0);
        chk({tag, "_addr"},  bus.prog_addr_o,           32'd0);
        chk({tag, "_data"},  bus.prog_data_o,           32'd0);
        chk({tag, "_cpurst"},{31'd0, bus.cpu_reset_o},  32'd1);
        chk({tag, "_done"},  {31'd0, bus.done_o},       32'd0);
        chk({tag, "_error"}, {31'd0, bus.error_o},      32'd0);
        chk({tag, "_count"}, {16'd0, bus.word_count_o}, 32'd0);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1, input int n);
        chk({tag, "_nwr"}, wr_addr.size(), n);
        if (wr_addr.size() >= 1) begin
            chk({tag, "_a0"}, wr_addr[0], a0);
            chk({tag, "_d0"}, wr_data[0], d0);
        end
        if (n > 1 && wr_addr.size() >= 2) begin
            chk({tag, "_a1"}, wr_addr[1], a1);
            chk({tag, "_d1"}, wr_data[1], d1);
        end
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        logic [7:0] nominal[] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        bus.start_i = 1'b0;
        bus.byte_i = 8'h00;
        bus.byte_valid_i = 1'b0;
        apply_reset();
        check_reset_vals("rst");

        // Nominal load, back-to-back bytes.
        pulse_start();
        send_stream(nominal, 0);
        chk("nom_we_last",   {31'd0, bus.prog_we_o}, 32'd1);
        chk("nom_addr_last", bus.prog_addr_o, 32'h4);
        chk("nom_data_last", bus.prog_data_o, 32'h01095020);
        chk("nom_done_early",{31'd0, bus.done_o}, 32'd0);
        @(negedge clk);
        chk("nom_done",   {31'd0, bus.done_o}, 32'd1);
        chk("nom_cpurst", {31'd0, bus.cpu_reset_o}, 32'd0);
        chk("nom_count",  {16'd0, bus.word_count_o}, 32'd2);
        @(negedge clk);
        check_writes("nom", 32'h0, 32'h20080005, 32'h4, 32'h01095020, 2);

        // Zero length.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("zero_check_done", {31'd0, bus.done_o}, 32'd0);
        chk("zero_check_rdy",  {31'd0, bus.byte_ready_o}, 32'd0);
        @(negedge clk);
        chk("zero_done",  {31'd0, bus.done_o}, 32'd1);
        chk("zero_count", {16'd0, bus.word_count_o}, 32'd0);
        check_writes("zero", 32'h0, 32'h0, 32'h0, 32'h0, 0);

        // Oversize: 65 words against a 64-word memory.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h41, 0);
        @(negedge clk);
        chk("ovr_error",  {31'd0, bus.error_o}, 32'd1);
        chk("ovr_cpurst", {31'd0, bus.cpu_reset_o}, 32'd1);
        chk("ovr_count",  {16'd0, bus.word_count_o}, 32'd65);
        repeat (3) @(negedge clk);
        check_writes("ovr", 32'h0, 32'h0, 32'h0, 32'h0, 0);
        pulse_start();
        chk("ovr_restart_rdy", {31'd0, bus.byte_ready_o}, 32'd1);
        chk("ovr_restart_err", {31'd0, bus.error_o}, 32'd0);

        // Random valid gaps give identical writes.
        apply_reset();
        pulse_start();
        send_stream(nominal, 3);
        repeat (2) @(negedge clk);
        chk("gap_done", {31'd0, bus.done_o}, 32'd1);
        check_writes("gap", 32'h0, 32'h20080005, 32'h4, 32'h01095020, 2);

        // Reset after two data bytes, then a fresh single-word load.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midrst");
        pulse_start();
        send_stream('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
        repeat (2) @(negedge clk);
        chk("midrst_done", {31'd0, bus.done_o}, 32'd1);
        check_writes("midrst", 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1);

        // Reload from DONE, with a stray start in the middle of a word.
        pulse_start();
        chk("reload_cpurst", {31'd0, bus.cpu_reset_o}, 32'd1);
        chk("reload_rdy",    {31'd0, bus.byte_ready_o}, 32'd1);
        send_stream('{8'h00, 8'h02, 8'hAA, 8'hBB}, 0);
        pulse_start();
        send_stream('{8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
        repeat (2) @(negedge clk);
        chk("reload_done", {31'd0, bus.done_o}, 32'd1);
        check_writes("reload", 32'h0, 32'hAABBCCDD, 32'h4, 32'h11223344, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
